timer_dev: RTL and testbench

- Programmable countdown timer occupying device slot 0 (0x7f00–0x7f0b) behind the CPU–device bridge.
- Consumes the bridge's device address bits [4:2], write data and slot-0 write enable.
- Returns read data to the bridge's slot-0 read port.
- Drives the slot-0 interrupt line, which becomes HWInt[0].

---
 rtl/timer_dev.sv | 121 ++++++++++++
 tb/tb_timer_dev.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Programmable countdown timer for device slot 0 of the CPU-device bridge.
// CTRL/PRESET/COUNT register file, four-state count FSM, maskable interrupt.
//
// state | meaning
// IDLE  | waiting for Enable; COUNT holds
// LOAD  | copy PRESET into COUNT
// CNT   | decrement COUNT toward the terminal value 0
// INT   | terminal count reached; one-shot clears Enable, auto-reload drops irq
module timer_dev #(
    parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'b000;
    localparam logic [2:0] A_PRESET = 3'b001;
    localparam logic [2:0] A_COUNT  = 3'b010;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_pend;

    state_t      w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_en_clr;
    logic        w_pend_set;
    logic        w_pend_fsm_clr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_enable;
    logic        w_auto_reload;

    assign w_wr_ctrl     = WE && (Addr == A_CTRL);
    assign w_wr_preset   = WE && (Addr == A_PRESET);
    assign w_enable      = r_ctrl[0];
    // Modes 10 and 11 fall back to one-shot.
    assign w_auto_reload = (r_ctrl[2:1] == 2'b01);

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_en_clr       = 1'b0;
        w_pend_set     = 1'b0;
        w_pend_fsm_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_enable) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == 32'd0) begin
                    w_pend_set  = 1'b1;
                    w_state_nxt = S_INT;
                end else begin
                    w_count_nxt = r_count - 32'd1;
                end
            end
            S_INT: begin
                if (w_auto_reload) w_pend_fsm_clr = 1'b1;
                else               w_en_clr       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'h0;
            r_preset   <= RST_PRESET;
            r_count    <= 32'd0;
            r_irq_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // A CPU write to CTRL overrides the one-shot Enable clear.
            if (w_wr_ctrl)     r_ctrl    <= DIN[3:0];
            else if (w_en_clr) r_ctrl[0] <= 1'b0;
            if (w_wr_preset)   r_preset  <= DIN;
            // Setting wins over a clearing write so a terminal count is never lost.
            if (w_pend_set)
                r_irq_pend <= 1'b1;
            else if (w_wr_ctrl || w_wr_preset || w_pend_fsm_clr)
                r_irq_pend <= 1'b0;
        end
    end

    always_comb begin
        DOUT = 32'h0;
        case (Addr)
            A_CTRL:   DOUT = {28'h0, r_ctrl};
            A_PRESET: DOUT = r_preset;
            A_COUNT:  DOUT = r_count;
            default:  DOUT = 32'h0;
        endcase
    end

    assign IRQ = r_irq_pend & r_ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: expected values are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_timer_dev;

    localparam logic [31:0] RSTP = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  Addr = 3'b000;
    logic        WE = 1'b0;
    logic [31:0] DIN = 32'h0;
    logic [31:0] DOUT;
    logic        IRQ;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    timer_dev #(.RST_PRESET(RSTP)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .IRQ   (IRQ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 32'hFFFF_FFFF;
        chk(tag, obs, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
        Addr = a;
        DIN  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = DOUT;
    endtask

    task automatic do_reset();
        WE    = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          k;
        bit          seen;

        // Reset values
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(RSTP);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(3'd0, v); chk_pop("rst_ctrl", v);
        rd(3'd1, v); chk_pop("rst_preset", v);
        rd(3'd2, v); chk_pop("rst_count", v);
        rd(3'd3, v); chk_pop("rst_addr3", v);
        chk("rst_irq", IRQ, 0);

        // One-shot, PRESET=5
        cpu_wr(3'd1, 32'd5);
        cpu_wr(3'd0, 32'h9);                        // E0
        for (int i = 5; i >= 0; i--) exp_q.push_back(i);
        step();                                     // E1
        for (int i = 0; i < 6; i++) begin           // E2..E7
            step();
            rd(3'd2, v);
            chk_pop("os_count", v);
        end
        chk("os_irq_pre", IRQ, 0);
        step();                                     // E8
        chk("os_irq_set", IRQ, 1);
        step();                                     // E9
        rd(3'd0, v); chk("os_ctrl_en_clr", v, 32'h8);
        step(); step();
        chk("os_irq_hold", IRQ, 1);
        cpu_wr(3'd0, 32'h8);
        chk("os_irq_ack", IRQ, 0);

        // Auto-reload, PRESET=3: pulses 6, 13, 20 cycles after the write edge
        do_reset();
        exp_q.delete();
        cpu_wr(3'd1, 32'd3);
        cpu_wr(3'd0, 32'hB);
        exp_q.push_back(6);
        exp_q.push_back(13);
        exp_q.push_back(20);
        for (int c = 1; c <= 22; c++) begin
            step();
            if (IRQ) chk_pop("ar_pulse_cycle", c);
        end
        chk("ar_pulses_missing", exp_q.size(), 0);
        exp_q.delete();

        // Masked interrupt
        do_reset();
        cpu_wr(3'd1, 32'd2);
        cpu_wr(3'd0, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (IRQ) seen = 1'b1;
        end
        chk("mask_irq_low", seen, 0);
        rd(3'd0, v); chk("mask_ctrl_en_clr", v, 32'h0);
        cpu_wr(3'd0, 32'h8);
        seen = IRQ;
        for (int i = 0; i < 4; i++) begin
            step();
            if (IRQ) seen = 1'b1;
        end
        chk("mask_after_ack", seen, 0);

        // Set beats a clearing write; CPU CTRL write beats the INT Enable clear
        do_reset();
        cpu_wr(3'd1, 32'd2);
        cpu_wr(3'd0, 32'h9);                        // E0
        step(); step(); step(); step();             // E1..E4, COUNT=0
        cpu_wr(3'd1, 32'd7);                        // E5: pend set + PRESET write
        chk("set_wins_irq", IRQ, 1);
        cpu_wr(3'd0, 32'h9);                        // E6: INT edge
        chk("int_wr_irq_clr", IRQ, 0);
        rd(3'd0, v); chk("int_wr_ctrl_wins", v, 32'h9);
        step(); step();                             // LOAD, then COUNT=PRESET
        rd(3'd2, v); chk("int_wr_reload", v, 32'd7);

        // PRESET=0
        do_reset();
        cpu_wr(3'd1, 32'd0);
        cpu_wr(3'd0, 32'h9);
        step(); step();
        rd(3'd2, v); chk("p0_count", v, 32'd0);
        chk("p0_irq_pre", IRQ, 0);
        step();
        chk("p0_irq_set", IRQ, 1);

        // Disable mid-count, read-only COUNT, unmapped reads, re-enable
        do_reset();
        cpu_wr(3'd1, 32'd10);
        cpu_wr(3'd0, 32'h1);
        k = 0;
        do begin
            step();
            rd(3'd2, v);
            k++;
        end while (v != 32'd6 && k < 20);
        chk("dis_reach6", v, 32'd6);
        cpu_wr(3'd0, 32'h0);                        // coincides with a decrement
        step();
        rd(3'd2, v); chk("dis_hold", v, 32'd5);
        step(); step();
        rd(3'd2, v); chk("dis_hold_later", v, 32'd5);
        cpu_wr(3'd2, 32'h1234);
        rd(3'd2, v); chk("count_ro", v, 32'd5);
        rd(3'd1, v); chk("preset_rd", v, 32'd10);
        step();
        for (int a = 3; a <= 7; a++) begin
            rd(3'(a), v);
            chk("unmapped_rd", v, 32'h0);
        end
        cpu_wr(3'd0, 32'h1);
        step(); step();
        rd(3'd2, v); chk("reenable_reload", v, 32'd10);

        // Reset during CNT
        step(); step();
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(RSTP);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(3'd0, v); chk_pop("cnt_rst_ctrl", v);
        rd(3'd1, v); chk_pop("cnt_rst_preset", v);
        rd(3'd2, v); chk_pop("cnt_rst_count", v);
        rd(3'd3, v); chk_pop("cnt_rst_addr3", v);
        chk("cnt_rst_irq", IRQ, 0);
        step(); step();
        rd(3'd2, v); chk("cnt_rst_idle", v, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
